// File: rtl/mem_sim_queue.sv
// mem_sim_queue -- small word memory behind an in-order request queue.
//
// Requests (READ / WRITE / ADD / reserved) are accepted on doit & !busy,
// queued, and serviced one at a time by a single engine that takes STEPS
// cycles per operation. READ and ADD answer with a one-cycle rvalid strobe
// and a registered rdata that holds until the next answer.
//
// Ports:
//   clk    in  1        clock, all state changes on rising edge
//   init   in  1        asynchronous active-high reset
//   addr   in  LOGSIZE  request word address
//   wdata  in  WIDTH    write data / ADD addend
//   op     in  2        00 READ, 01 WRITE, 10 ADD, 11 reserved
//   doit   in  1        request strobe
//   busy   out 1        queue full, request not accepted
//   idle   out 1        nothing outstanding
//   rvalid out 1        one-cycle response strobe
//   rdata  out WIDTH    response data
//   err    out 1        sticky: reserved op completed
module mem_sim_queue #(
  parameter int LOGSIZE = 4,
  parameter int WIDTH   = 8,
  parameter int STEPS   = 3,
  parameter int QDEPTH  = 4
) (
  input  logic               clk,
  input  logic               init,
  input  logic [LOGSIZE-1:0] addr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [1:0]         op,
  input  logic               doit,
  output logic               busy,
  output logic               idle,
  output logic               rvalid,
  output logic [WIDTH-1:0]   rdata,
  output logic               err
);

  localparam int DEPTH = 1 << LOGSIZE;
  localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int OW    = PW + 1;
  localparam int CW    = 12;

  localparam logic [OW-1:0] OCC_ONE  = OW'(1);
  localparam logic [OW-1:0] OCC_FULL = OW'(QDEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STEPS);

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ADD   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  // Memory and queue storage are flops because reset must clear them.
  logic [WIDTH-1:0]   mem_q   [DEPTH];
  logic [LOGSIZE-1:0] q_addr_q[QDEPTH];
  logic [WIDTH-1:0]   q_data_q[QDEPTH];
  logic [1:0]         q_op_q  [QDEPTH];

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    occ_q, occ_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q, err_q;

  logic               accept, complete;
  logic [LOGSIZE-1:0] head_addr;
  logic [WIDTH-1:0]   head_data, head_mem, head_sum;
  op_e                head_op;

  // Status comes only from registered occupancy, so doit never reaches busy.
  assign busy   = (occ_q == OCC_FULL);
  assign idle   = (occ_q == '0);
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

  assign accept   = doit & ~busy;
  // The head entry is the one in service whenever occupancy is non-zero.
  assign complete = (occ_q != '0) && (cnt_q == CNT_ONE);

  assign head_addr = q_addr_q[rd_ptr_q];
  assign head_data = q_data_q[rd_ptr_q];
  assign head_op   = op_e'(q_op_q[rd_ptr_q]);
  assign head_mem  = mem_q[head_addr];
  assign head_sum  = head_mem + head_data;

  always_comb begin
    occ_d = occ_q;
    if (accept && !complete) begin
      occ_d = occ_q + OCC_ONE;
    end else if (!accept && complete) begin
      occ_d = occ_q - OCC_ONE;
    end
  end

  // Service counter: loads on a bypass start into an empty block, reloads
  // at a completion edge when more work remains, otherwise counts down.
  always_comb begin
    cnt_d = cnt_q;
    if (complete) begin
      cnt_d = (occ_d != '0) ? CNT_LOAD : '0;
    end else if (occ_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end else if (accept) begin
      cnt_d = CNT_LOAD;
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_addr_q[i] <= '0;
        q_data_q[i] <= '0;
        q_op_q[i]   <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      if (accept) begin
        q_addr_q[wr_ptr_q] <= addr;
        q_data_q[wr_ptr_q] <= wdata;
        q_op_q[wr_ptr_q]   <= op;
        wr_ptr_q           <= wr_ptr_q + PTR_ONE;
      end
      if (complete) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (complete) begin
        case (head_op)
          OP_READ: begin
            rdata_q  <= head_mem;
            rvalid_q <= 1'b1;
          end
          OP_WRITE: begin
            mem_q[head_addr] <= head_data;
          end
          OP_ADD: begin
            mem_q[head_addr] <= head_sum;
            rdata_q          <= head_sum;
            rvalid_q         <= 1'b1;
          end
          default: begin
            err_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_sim_queue.sv
module tb_mem_sim_queue;

  localparam int LOGSIZE    = 4;
  localparam int WIDTH      = 8;
  localparam int STEPS      = 3;
  localparam int QDEPTH     = 4;
  localparam int SLOW_STEPS = 8;
  localparam int NVEC       = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic               init, doit, busy, idle, rvalid, err;
  logic [LOGSIZE-1:0] addr;
  logic [WIDTH-1:0]   wdata, rdata;
  logic [1:0]         op;

  // Slow instance: long service time so the queue fills before anything completes
  logic               s_init, s_doit, s_busy, s_idle, s_rvalid, s_err;
  logic [LOGSIZE-1:0] s_addr;
  logic [WIDTH-1:0]   s_wdata, s_rdata;
  logic [1:0]         s_op;

  mem_sim_queue #(.LOGSIZE(LOGSIZE), .WIDTH(WIDTH), .STEPS(STEPS), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .init(init), .addr(addr), .wdata(wdata), .op(op), .doit(doit),
    .busy(busy), .idle(idle), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  mem_sim_queue #(.LOGSIZE(LOGSIZE), .WIDTH(WIDTH), .STEPS(SLOW_STEPS), .QDEPTH(QDEPTH)) dut_slow (
    .clk(clk), .init(s_init), .addr(s_addr), .wdata(s_wdata), .op(s_op), .doit(s_doit),
    .busy(s_busy), .idle(s_idle), .rvalid(s_rvalid), .rdata(s_rdata), .err(s_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       doit;
    logic [1:0] op;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       idle;
    logic       rvalid;
    logic [7:0] rdata;
    logic       err;
  } vec_t;

  vec_t tbl[NVEC];

  task automatic tv(input int i, input logic d, input logic [1:0] o, input logic [3:0] a,
                    input logic [7:0] w, input logic b, input logic id, input logic rv,
                    input logic [7:0] rd, input logic e);
    tbl[i].doit = d;   tbl[i].op = o;     tbl[i].addr = a;     tbl[i].wdata = w;
    tbl[i].busy = b;   tbl[i].idle = id;  tbl[i].rvalid = rv;  tbl[i].rdata = rd;
    tbl[i].err = e;
  endtask

  // ---------------- reference model ----------------
  // Each accepted request is given its completion edge up front:
  // done = max(accept edge, previous request's done) + STEPS.
  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         done;
  } req_t;

  req_t       mq[$];
  logic [7:0] mmem[16];
  int         t, last_done;
  logic       m_busy, m_idle, m_rvalid, m_err;
  logic [7:0] m_rdata;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 16; i++) mmem[i] = 8'h00;
    t = 0; last_done = 0;
    m_busy = 1'b0; m_idle = 1'b1; m_rvalid = 1'b0; m_rdata = 8'h00; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic d, input logic [1:0] o, input logic [3:0] a,
                            input logic [7:0] w);
    bit   full;
    req_t r;
    full = (mq.size() == QDEPTH);
    t++;
    m_rvalid = 1'b0;
    if (mq.size() > 0 && mq[0].done == t) begin
      r = mq.pop_front();
      case (r.op)
        2'b00: begin m_rdata = mmem[r.addr]; m_rvalid = 1'b1; end
        2'b01: mmem[r.addr] = r.wdata;
        2'b10: begin
          mmem[r.addr] = mmem[r.addr] + r.wdata;
          m_rdata = mmem[r.addr];
          m_rvalid = 1'b1;
        end
        default: m_err = 1'b1;
      endcase
    end
    if (d && !full) begin
      r.op = o; r.addr = a; r.wdata = w;
      r.done = ((last_done > t) ? last_done : t) + STEPS;
      last_done = r.done;
      mq.push_back(r);
    end
    m_busy = (mq.size() == QDEPTH);
    m_idle = (mq.size() == 0);
  endtask

  // ---------------- helpers ----------------
  task automatic compare(input string name, input logic e_busy, input logic e_idle,
                         input logic e_rvalid, input logic [7:0] e_rdata, input logic e_err);
    vectors++;
    if ({busy, idle, rvalid, rdata, err} !== {e_busy, e_idle, e_rvalid, e_rdata, e_err}) begin
      miscompares++;
      $display("FAIL %s t=%0d: got busy=%b idle=%b rvalid=%b rdata=%02h err=%b, want busy=%b idle=%b rvalid=%b rdata=%02h err=%b",
               name, t, busy, idle, rvalid, rdata, err, e_busy, e_idle, e_rvalid, e_rdata, e_err);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, advance the model, sample 1 ns later.
  task automatic step(input logic d, input logic [1:0] o, input logic [3:0] a, input logic [7:0] w);
    doit = d; op = o; addr = a; wdata = w;
    @(posedge clk);
    model_edge(d, o, a, w);
    #1;
  endtask

  task automatic step_chk(input string name, input logic d, input logic [1:0] o,
                          input logic [3:0] a, input logic [7:0] w);
    step(d, o, a, w);
    compare(name, m_busy, m_idle, m_rvalid, m_rdata, m_err);
  endtask

  task automatic do_reset();
    doit = 1'b0; s_doit = 1'b0;
    init = 1'b1; s_init = 1'b1;
    model_reset();
    #1;
    compare("reset_hold", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    init = 1'b0; s_init = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    logic       d;
    logic [1:0] o;
    logic [3:0] a;
    logic [7:0] w;
    int         cnt;

    init = 1'b1; doit = 1'b0; op = 2'b00; addr = '0; wdata = '0;
    s_init = 1'b1; s_doit = 1'b0; s_op = 2'b00; s_addr = '0; s_wdata = '0;

    //    i  doit op     addr  wdata  | busy idle rv rdata  err
    tv( 0, 1, 2'b00, 4'd5, 8'h00,  0, 0, 0, 8'h00, 0); // READ 5 into empty block
    tv( 1, 0, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h00, 0);
    tv( 2, 0, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h00, 0);
    tv( 3, 0, 2'b00, 4'd0, 8'h00,  0, 1, 1, 8'h00, 0); // completes 3 edges after accept
    tv( 4, 0, 2'b00, 4'd0, 8'h00,  0, 1, 0, 8'h00, 0);
    tv( 5, 1, 2'b01, 4'd2, 8'h41,  0, 0, 0, 8'h00, 0); // WRITE 0x41 -> 2
    tv( 6, 1, 2'b00, 4'd2, 8'h00,  0, 0, 0, 8'h00, 0); // READ 2 next edge
    tv( 7, 0, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h00, 0);
    tv( 8, 0, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h00, 0); // write done, no strobe
    tv( 9, 0, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h00, 0);
    tv(10, 0, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h00, 0);
    tv(11, 0, 2'b00, 4'd0, 8'h00,  0, 1, 1, 8'h41, 0); // 6 edges after first accept
    tv(12, 0, 2'b00, 4'd0, 8'h00,  0, 1, 0, 8'h41, 0); // rdata held
    tv(13, 1, 2'b01, 4'd0, 8'h01,  0, 0, 0, 8'h41, 0); // mem[0] = 0x01
    tv(14, 1, 2'b10, 4'd0, 8'hFF,  0, 0, 0, 8'h41, 0); // ADD 0xFF to mem[0]
    tv(15, 0, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h41, 0);
    tv(16, 0, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h41, 0);
    tv(17, 0, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h41, 0);
    tv(18, 0, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h41, 0);
    tv(19, 0, 2'b00, 4'd0, 8'h00,  0, 1, 1, 8'h00, 0); // 0x01 + 0xFF wraps to 0x00
    tv(20, 1, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h00, 0); // read back mem[0]
    tv(21, 0, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h00, 0);
    tv(22, 0, 2'b00, 4'd0, 8'h00,  0, 0, 0, 8'h00, 0);
    tv(23, 0, 2'b00, 4'd0, 8'h00,  0, 1, 1, 8'h00, 0);

    do_reset();

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].doit, tbl[i].op, tbl[i].addr, tbl[i].wdata);
      compare($sformatf("vec%0d", i), tbl[i].busy, tbl[i].idle, tbl[i].rvalid,
              tbl[i].rdata, tbl[i].err);
      $display("vec %0d: doit=%b op=%b addr=%0d wdata=%02h -> busy=%b idle=%b rvalid=%b rdata=%02h err=%b",
               i, tbl[i].doit, tbl[i].op, tbl[i].addr, tbl[i].wdata, busy, idle, rvalid, rdata, err);
    end

    // Full queue on the slow instance: five back-to-back requests, four taken.
    for (int i = 0; i < 5; i++) begin
      s_doit = 1'b1; s_op = 2'b00; s_addr = 4'(i); s_wdata = 8'h00;
      @(posedge clk);
      #1;
      check_val($sformatf("slow_busy%0d", i), int'(s_busy), (i >= 3) ? 1 : 0);
      $display("slow req %0d: busy=%b idle=%b", i, s_busy, s_idle);
    end
    s_doit = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5 * SLOW_STEPS; i++) begin
      @(posedge clk);
      #1;
      if (s_rvalid) cnt++;
    end
    check_val("slow_completions", cnt, 4);
    check_val("slow_idle_after", int'(s_idle), 1);
    $display("slow completions counted: %0d", cnt);

    // Reserved op: memory untouched, no strobe, sticky err.
    do_reset();
    step_chk("rsvd_w", 1'b1, 2'b01, 4'd3, 8'h5A);
    step_chk("rsvd_op", 1'b1, 2'b11, 4'd3, 8'h11);
    for (int i = 0; i < 5; i++) step_chk("rsvd_wait", 1'b0, 2'b00, 4'd0, 8'h00);
    check_val("rsvd_err_set", int'(err), 1);
    step_chk("rsvd_rd", 1'b1, 2'b00, 4'd3, 8'h00);
    for (int i = 0; i < 3; i++) step_chk("rsvd_rdw", 1'b0, 2'b00, 4'd0, 8'h00);
    check_val("rsvd_mem_kept", int'(rdata), 8'h5A);
    check_val("rsvd_err_sticky", int'(err), 1);
    $display("reserved op: err=%b readback=%02h", err, rdata);

    // init one cycle after a WRITE accept: write discarded.
    do_reset();
    step_chk("abort_w", 1'b1, 2'b01, 4'd6, 8'h77);
    step_chk("abort_gap", 1'b0, 2'b00, 4'd0, 8'h00);
    #2;
    init = 1'b1;
    model_reset();
    #1;
    compare("abort_idle", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_val("abort_no_rvalid", int'(rvalid), 0);
    end
    init = 1'b0;
    step_chk("abort_rd", 1'b1, 2'b00, 4'd6, 8'h00);
    for (int i = 0; i < 3; i++) step_chk("abort_rdw", 1'b0, 2'b00, 4'd0, 8'h00);
    check_val("abort_rvalid", int'(rvalid), 1);
    check_val("abort_mem", int'(rdata), 0);
    $display("abort: readback=%02h rvalid=%b", rdata, rvalid);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      d = ($urandom_range(0, 9) < 6);
      cnt = $urandom_range(0, 19);
      o = (cnt == 0) ? 2'b11 : 2'(cnt % 3);
      a = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      w = 8'($urandom);
      step_chk("rand", d, o, a, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_sim_queue.md
MEM_SIM_QUEUE -- requirements
Module: mem_sim_queue

Interface
REQ-001 SHALL have parameter LOGSIZE, default 4: address width; memory holds 2**LOGSIZE words.
REQ-002 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-003 SHALL have parameter STEPS, default 3: per-operation service latency in cycles; legal range 1..4095.
REQ-004 SHALL have parameter QDEPTH, default 4: maximum outstanding requests; power of two, 2..16.
REQ-005 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 SHALL have port init, input, 1: reset; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port addr, input, LOGSIZE: request word address.
REQ-008 SHALL have port wdata, input, WIDTH: write data, or addend for ADD.
REQ-009 SHALL have port op, input, 2: 00 READ, 01 WRITE, 10 ADD, 11 reserved.
REQ-010 SHALL have port doit, input, 1: request strobe.
REQ-011 SHALL have port busy, output, 1: queue full; request not accepted.
REQ-012 SHALL have port idle, output, 1: no request outstanding.
REQ-013 SHALL have port rvalid, output, 1: one-cycle response strobe.
REQ-014 SHALL have port rdata, output, WIDTH: response data.
REQ-015 SHALL have port err, output, 1: sticky flag, reserved op seen.

Function
REQ-016 Accept rule SHALL be doit & !busy at a rising edge; addr, wdata and op SHALL be captured at that edge, and doit while busy SHALL be ignored with no state change.
REQ-017 Occupancy SHALL count accepted-but-not-completed requests, including the one in service, over range 0..QDEPTH.
REQ-018 busy SHALL equal (occupancy == QDEPTH) and idle SHALL equal (occupancy == 0), both decoded from registered state only, with no combinational path from doit.
REQ-019 Requests SHALL be serviced strictly in acceptance order by one service engine holding a down-counter.
REQ-020 Service start: if the engine is free, the head request SHALL start at the same edge it is accepted (bypass) or is first at head; counter SHALL load STEPS.
REQ-021 Completion SHALL occur at the edge where counter == 1; the next queued request, if any, SHALL start at that same edge, giving back-to-back throughput of one operation per STEPS cycles.
REQ-022 Request accepted at edge k into an idle block SHALL complete at edge k+STEPS.
REQ-023 At completion, WRITE SHALL set mem[addr] = wdata with no rvalid.
REQ-024 At completion, READ SHALL produce rdata = mem[addr] as of that edge, reflecting all earlier completed writes and adds.
REQ-025 At completion, ADD SHALL set mem[addr] = (mem[addr] + wdata) mod 2**WIDTH and SHALL return the new value in rdata.
REQ-026 At completion, the reserved op SHALL leave memory unchanged, produce no rvalid, and set err.
REQ-027 rvalid SHALL be high for exactly the one cycle following a READ or ADD completion edge.
REQ-028 rdata SHALL be registered and held until the next READ or ADD completion.
REQ-029 Accept and completion on the same edge SHALL both take effect, leaving occupancy unchanged.
REQ-030 A full queue SHALL block acceptance even on a completion edge, with busy deasserting the cycle after.
REQ-031 Queue pointers SHALL wrap modulo QDEPTH, and address arithmetic SHALL NOT wrap beyond 2**LOGSIZE - 1.

Reset
REQ-032 init high SHALL asynchronously clear memory, queue contents and pointers, occupancy, counter, rdata (to 0), rvalid, and err.
REQ-033 During reset, busy SHALL be 0 and idle SHALL be 1.
REQ-034 init mid-operation SHALL discard all outstanding requests without memory update or rvalid.
REQ-035 Requests SHALL be accepted from the first rising edge after init deasserts.

Verification
REQ-036 Defaults, after reset: READ addr 5 -> rvalid exactly 3 cycles after accept, rdata=0x00, idle=1 afterward.
REQ-037 WRITE 0x41 to addr 2, READ addr 2, issued on consecutive edges -> one rvalid, rdata=0x41, 6 cycles after first accept.
REQ-038 ADD 0xFF to addr 0 holding 0x01 -> rvalid with rdata=0x00 and mem[0]=0x00 (wrap).
REQ-039 Five doit pulses on consecutive cycles with QDEPTH=4 -> busy high after the fourth accept, fifth request ignored, exactly 4 completions observed.
REQ-040 op=11 -> no rvalid, memory unchanged, err=1 until init.
REQ-041 init asserted 1 cycle after a WRITE accept -> no memory change, idle=1 immediately, no rvalid.
